// File: rtl/lrn_norm_scheduler.sv
// -----------------------------------------------------------------------------
// lrn_norm_scheduler
//
// Layer-level controller for the LRN normalization datapath. A layer is started
// with a vector count; the scheduler then admits upstream square_sum/lrn_center
// vector pairs into the datapath. It never lets more vectors be in flight than
// the datapath input FIFOs can hold. It counts returned (normalized) vectors
// and pulses done when the whole layer has come back.
//
// Handshake: an upstream vector is transferred in any cycle where in_valid and
// in_ready are both high. in_ready never depends on in_valid. The transfer is
// echoed to the datapath as norm_enable in the same cycle. The datapath gives
// no back-pressure on its output side: every norm_out_valid pulse is one
// completed vector and is always consumed.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_start           one-cycle layer start pulse (honoured only in IDLE)
//   cfg_num_vectors     vectors in the layer, latched on an accepted start
//   in_valid/in_ready   upstream vector handshake
//   norm_enable         push strobe into both datapath input FIFOs
//   norm_out_valid      one pulse per vector leaving the datapath
//   busy                registered, high while in RUN or DRAIN
//   done                one-cycle pulse, high while the FSM sits in DONE
//   err_overflow        sticky: a return arrived with nothing in flight
//   issued_cnt          vectors issued in the current layer
//   recv_cnt            vectors returned in the current layer
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//   dbg_credits         free datapath slots (MAX_INFLIGHT when idle)
//
// Optional feature, enabled by defining LRN_SCHED_PERF_EN:
//   perf_cycles         cycles spent in RUN or DRAIN during the current layer
//   perf_stall          RUN cycles where upstream was valid but no credit was left
//   Both counters clear on reset and on an accepted start. They hold their
//   values after done.
// -----------------------------------------------------------------------------
module lrn_norm_scheduler #(
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic [CNT_WIDTH-1:0]    cfg_num_vectors,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    norm_enable,
  input  logic                    norm_out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overflow,
  output logic [CNT_WIDTH-1:0]    issued_cnt,
  output logic [CNT_WIDTH-1:0]    recv_cnt,
  output logic [1:0]              dbg_state,
  output logic [CREDIT_WIDTH-1:0] dbg_credits
`ifdef LRN_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE    = CNT_WIDTH'(1);

  state_t                  state;
  logic [CNT_WIDTH-1:0]    num;
  logic [CREDIT_WIDTH-1:0] credits;

  logic                    active;
  logic                    ret_ok;
  logic                    ret_err;
  logic [CNT_WIDTH-1:0]    issued_next;
  logic [CNT_WIDTH-1:0]    recv_next;
  logic                    issue_last;
  logic                    recv_last;

  assign active = (state == S_RUN) || (state == S_DRAIN);

  // Admission uses only registered state. A credit returned this cycle becomes
  // usable on the next cycle.
  assign in_ready    = (state == S_RUN) && (issued_cnt < num) && (credits != '0);
  assign norm_enable = in_valid && in_ready;

  // A return is real only while a layer is active and something is in flight.
  // Any other return is flagged and does not touch the counters or credits.
  assign ret_ok  = norm_out_valid && active && (credits != CREDIT_MAX);
  assign ret_err = norm_out_valid && !ret_ok;

  assign issued_next = norm_enable ? (issued_cnt + CNT_ONE) : issued_cnt;
  assign recv_next   = ret_ok      ? (recv_cnt + CNT_ONE)   : recv_cnt;

  // Transitions look at the post-update counts. The state therefore moves
  // in the same edge that makes the registered count reach num.
  assign issue_last = (issued_next == num);
  assign recv_last  = (recv_next == num);

  assign dbg_state   = state;
  assign dbg_credits = credits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      num          <= '0;
      issued_cnt   <= '0;
      recv_cnt     <= '0;
      credits      <= CREDIT_MAX;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (cfg_start) begin
            num          <= cfg_num_vectors;
            issued_cnt   <= '0;
            recv_cnt     <= '0;
            credits      <= CREDIT_MAX;
            err_overflow <= 1'b0;
            if (cfg_num_vectors == '0) begin
              // An empty layer completes without ever being busy.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end else if (ret_err) begin
            err_overflow <= 1'b1;
          end
        end

        S_RUN, S_DRAIN: begin
          issued_cnt <= issued_next;
          recv_cnt   <= recv_next;
          // Issue and return in the same cycle cancel out.
          if (norm_enable && !ret_ok) begin
            credits <= credits - CREDIT_ONE;
          end else if (ret_ok && !norm_enable) begin
            credits <= credits + CREDIT_ONE;
          end
          if (ret_err) begin
            err_overflow <= 1'b1;
          end

          if (issue_last && recv_last) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (state == S_RUN && issue_last) begin
            state <= S_DRAIN;
            done  <= 1'b0;
            busy  <= 1'b1;
          end else begin
            done <= 1'b0;
            busy <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          if (ret_err) begin
            err_overflow <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LRN_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE && cfg_start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (active) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      // Only credit starvation counts as a stall. Running out of vectors
      // to issue does not.
      if (state == S_RUN && in_valid && !in_ready && credits == '0) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lrn_norm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lrn_norm_scheduler
//
// Directed bench for lrn_norm_scheduler. Inputs are driven at the falling
// edge. Outputs are sampled 1 ns later, which keeps sampling away from the
// rising (active) edge. Registered outputs seen there reflect the previous
// rising edge. Combinational outputs reflect the inputs just driven.
// -----------------------------------------------------------------------------
module tb_lrn_norm_scheduler;

  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          cfg_start;
  logic [CW-1:0] cfg_num_vectors;
  logic          in_valid;
  logic          in_ready;
  logic          norm_enable;
  logic          norm_out_valid;
  logic          busy;
  logic          done;
  logic          err_overflow;
  logic [CW-1:0] issued_cnt;
  logic [CW-1:0] recv_cnt;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_credits;
`ifdef LRN_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];   // expected issue cycles
  int          ret_q[$];   // cycles at which the modelled datapath returns

  lrn_norm_scheduler #(
    .CNT_WIDTH    (CW),
    .MAX_INFLIGHT (4),
    .CREDIT_WIDTH (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_num_vectors (cfg_num_vectors),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .norm_enable     (norm_enable),
    .norm_out_valid  (norm_out_valid),
    .busy            (busy),
    .done            (done),
    .err_overflow    (err_overflow),
    .issued_cnt      (issued_cnt),
    .recv_cnt        (recv_cnt),
    .dbg_state       (dbg_state),
    .dbg_credits     (dbg_credits)
`ifdef LRN_SCHED_PERF_EN
    ,
    .perf_cycles     (perf_cycles),
    .perf_stall      (perf_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic start, input logic [CW-1:0] num,
                       input logic valid, input logic ret);
    cfg_start       = start;
    cfg_num_vectors = num;
    in_valid        = valid;
    norm_out_valid  = ret;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Drives in_valid high and returns one vector per cycle while the modelled
  // datapath holds any. It finishes the layer and checks the final counts.
  task automatic run_layer(input string tag, input int exp_num, input int init_inflight);
    int   inflight;
    int   c;
    logic ret;
    inflight = init_inflight;
    c = 0;
    while (!done && c < 300) begin
      ret = (inflight > 0);
      drive(1'b0, '0, 1'b1, ret);
      if (norm_enable) inflight++;
      if (ret) inflight--;
      next_cycle();
      c++;
    end
    check({tag, "_done"},   32'(done),       32'd1);
    check({tag, "_issued"}, 32'(issued_cnt), 32'(exp_num));
    check({tag, "_recv"},   32'(recv_cnt),   32'(exp_num));
    check({tag, "_busy"},   32'(busy),       32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    next_cycle();
    check({tag, "_done_drop"}, 32'(done),      32'd0);
    check({tag, "_idle"},      32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r;
    logic e;

    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) next_cycle();

    // Reset state. in_valid is held high so that in_ready is actually exercised.
    check("rst_in_ready", 32'(in_ready),     32'd0);
    check("rst_enable",   32'(norm_enable),  32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_err",      32'(err_overflow), 32'd0);
    check("rst_issued",   32'(issued_cnt),   32'd0);
    check("rst_recv",     32'(recv_cnt),     32'd0);
    check("rst_credits",  32'(dbg_credits),  32'd4);
    check("rst_state",    32'(dbg_state),    32'd0);
    reset = 1'b0;

    // ---- Layer 1: num = 0 goes straight to DONE and is never busy ----
    drive(1'b1, 16'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l1_done",   32'(done),       32'd1);
    check("l1_state",  32'(dbg_state),  32'd3);
    check("l1_busy",   32'(busy),       32'd0);
    check("l1_issued", 32'(issued_cnt), 32'd0);
    check("l1_recv",   32'(recv_cnt),   32'd0);
    next_cycle();
    check("l1_done_drop", 32'(done),      32'd0);
    check("l1_busy_idle", 32'(busy),      32'd0);
    check("l1_idle",      32'(dbg_state), 32'd0);

    // ---- Layer 2: num = 3, datapath latency of 6 cycles ----
    // Issues are expected at cycles 1-2-3 and returns at 7-8-9, so done is
    // expected at cycle 10.
    exp_q = '{32'd1, 32'd2, 32'd3};
    ret_q.delete();
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    next_cycle();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      r = 1'b0;
      if (ret_q.size() > 0 && ret_q[0] == cyc) begin
        r = 1'b1;
        void'(ret_q.pop_front());
      end
      drive(1'b0, '0, 1'b1, r);
      e = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
        e = 1'b1;
        void'(exp_q.pop_front());
      end
      check($sformatf("l2_enable_c%0d", cyc), 32'(norm_enable), 32'(e));
      check($sformatf("l2_busy_c%0d", cyc),   32'(busy),        32'(cyc >= 1 && cyc <= 9));
      check($sformatf("l2_done_c%0d", cyc),   32'(done),        32'(cyc == 10));
      if (cyc == 4) begin
        check("l2_drain_state", 32'(dbg_state), 32'd2);
        check("l2_drain_ready", 32'(in_ready),  32'd0);
      end
      if (cyc == 10) begin
        check("l2_issued", 32'(issued_cnt), 32'd3);
        check("l2_recv",   32'(recv_cnt),   32'd3);
      end
      if (norm_enable) ret_q.push_back(cyc + 6);
      next_cycle();
    end
    check("l2_ret_q_empty", 32'(ret_q.size()), 32'd0);

    // ---- Layer 3: credit limit, num = 10, no returns for 20 cycles ----
    drive(1'b1, 16'd10, 1'b0, 1'b0);
    next_cycle();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("l3_ready_c%0d", cyc),  32'(in_ready),    32'(cyc <= 4));
      check($sformatf("l3_enable_c%0d", cyc), 32'(norm_enable), 32'(cyc <= 4));
      next_cycle();
    end
    check("l3_issued_4",  32'(issued_cnt),  32'd4);
    check("l3_credits_0", 32'(dbg_credits), 32'd0);
    // A return while at zero credits frees a slot only from the next cycle.
    drive(1'b0, '0, 1'b1, 1'b1);
    check("l3_ret_ready",  32'(in_ready),    32'd0);
    check("l3_ret_enable", 32'(norm_enable), 32'd0);
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("l3_credits_1",  32'(dbg_credits), 32'd1);
    check("l3_recv_1",     32'(recv_cnt),    32'd1);
    check("l3_one_more",   32'(norm_enable), 32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1);
    check("l3_ready_again0", 32'(in_ready),    32'd0);
    check("l3_credits_0b",   32'(dbg_credits), 32'd0);
    check("l3_issued_5",     32'(issued_cnt),  32'd5);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1);
    check("l3_credits_1b", 32'(dbg_credits), 32'd1);
    next_cycle();
    // Simultaneous issue and return at two credits.
    drive(1'b0, '0, 1'b1, 1'b1);
    check("l3_credits_2",   32'(dbg_credits), 32'd2);
    check("l3_sim_enable",  32'(norm_enable), 32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l3_credits_2_hold", 32'(dbg_credits), 32'd2);
    check("l3_issued_6",       32'(issued_cnt),  32'd6);
    check("l3_recv_4",         32'(recv_cnt),    32'd4);
    run_layer("l3", 10, 2);

    // ---- Layer 4: overflow error in IDLE and in RUN, start ignored in RUN ----
    drive(1'b0, '0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l4_err_idle",     32'(err_overflow), 32'd1);
    check("l4_recv_untouch", 32'(recv_cnt),     32'd10);
    next_cycle();
    check("l4_err_sticky", 32'(err_overflow), 32'd1);
    drive(1'b1, 16'd2, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 16'd7, 1'b0, 1'b1);   // ignored start and a bogus return in RUN
    check("l4_err_clear",  32'(err_overflow), 32'd0);
    check("l4_recv_clear", 32'(recv_cnt),     32'd0);
    check("l4_iss_clear",  32'(issued_cnt),   32'd0);
    check("l4_busy",       32'(busy),         32'd1);
    check("l4_run",        32'(dbg_state),    32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l4_err_run",     32'(err_overflow), 32'd1);
    check("l4_recv_run",    32'(recv_cnt),     32'd0);
    check("l4_credits_run", 32'(dbg_credits),  32'd4);
    run_layer("l4", 2, 0);
    check("l4_err_after_done", 32'(err_overflow), 32'd1);

    // ---- Layer 5: reset in DRAIN with 2 of 5 returned ----
    drive(1'b1, 16'd5, 1'b0, 1'b0);
    next_cycle();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("l5_enable_c%0d", cyc), 32'(norm_enable), 32'd1);
      next_cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    check("l5_full_ready", 32'(in_ready), 32'd0);
    next_cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("l5_fifth_issue", 32'(norm_enable), 32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1);
    check("l5_drain",    32'(dbg_state),  32'd2);
    check("l5_issued_5", 32'(issued_cnt), 32'd5);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l5_recv_2",      32'(recv_cnt),  32'd2);
    check("l5_drain_again", 32'(dbg_state), 32'd2);
    check("l5_drain_busy",  32'(busy),      32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 16'd1, 1'b0, 1'b0);
    check("l5_rst_state",   32'(dbg_state),   32'd0);
    check("l5_rst_busy",    32'(busy),        32'd0);
    check("l5_rst_done",    32'(done),        32'd0);
    check("l5_rst_credits", 32'(dbg_credits), 32'd4);
    check("l5_rst_recv",    32'(recv_cnt),    32'd0);
    check("l5_rst_issued",  32'(issued_cnt),  32'd0);
    next_cycle();
    run_layer("l5b", 1, 0);

    // ---- Start accepted right after done ----
    drive(1'b1, 16'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("l6_done",  32'(done),      32'd1);
    check("l6_state", 32'(dbg_state), 32'd3);
    next_cycle();
    check("l6_done_drop", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
